reg_file: RTL and testbench
===========================

# reg_file

Register file for the 5-stage MIPS pipeline: 32 general-purpose 32-bit registers with one write port (driven by write-back) and two read ports (consumed by decode). Read results are captured into a registered operand latch that feeds the ID/EX boundary. The latch has stall (hold) and flush (bubble) control. Register $0 is hardwired to zero, and a same-cycle write to a register being read is bypassed to the read result.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; NUM_REGS = 2^ADDR_W = 32
- clock  in  1  single clock; all state updates on posedge
- reset_0  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- we  in  1  write enable from write-back stage
- waddr  in  ADDR_W  destination register
- wdata  in  DATA_W  write-back data
- raddr_a  in  ADDR_W  rs read address
- raddr_b  in  ADDR_W  rt read address
- rd_en  in  1  capture read results into operand latch (0 = stall, hold latch)
- flush  in  1  load a bubble into operand latch
- rdata_a  out  DATA_W  registered rs operand
- rdata_b  out  DATA_W  registered rt operand
- rvalid  out  1  operand latch holds a real (non-bubble) read

## Operation
- Storage: registers 1..31, each a 32-bit enabled register; register 0 has no storage and always reads 0.
- Write: on posedge with we=1 and waddr≠0, reg[waddr] <= wdata. A write with waddr=0 is discarded silently.
- Read path, evaluated combinationally in the cycle of capture:
  - raddr=0 → 0.
  - Else if we=1 and waddr=raddr → wdata (write-first bypass).
  - Else reg[raddr].
  - Ports a and b are independent; both may address the same register.
- Operand latch update, per posedge, in priority order:
  - flush=1: rdata_a <= 0, rdata_b <= 0, rvalid <= 0.
  - Else rd_en=1: rdata_a/rdata_b <= read-path values, rvalid <= 1.
  - Else: hold all three outputs.
- Writes are never blocked by rd_en or flush.

## Timing
- Reset (reset_0=0, asynchronous): all 31 registers = 0, rdata_a = rdata_b = 0, rvalid = 0, immediately and independent of the clock. Deassertion takes effect at the next posedge.
- Read latency is 1 cycle: addresses presented in cycle N appear on rdata_* after posedge N+1 when rd_en=1.
- Write to read visibility:
  - Same-cycle write and read of the same address: the latch captures the new wdata.
  - Write in cycle N, read in cycle N+1: captures the stored new value.
- Stall holds rdata_* stable indefinitely. A write during a stall to a register already latched does NOT update the latch; decode must re-issue the read.
- flush and rd_en asserted together: flush wins, and the bubble is captured.
- Reset asserted mid-operation: a write in flight in that cycle is lost, and all state is zeroed.

## Structure
- Shared constants file: DATA_W, ADDR_W, NUM_REGS, ZERO_REG (= 0).
- Sub-module reg_cell: the 32-bit enabled register with async active-low reset, instantiated 31 times. Each enable is (we && waddr==i), produced by a one-hot write decoder in the top level.
- Top level contains the write decoder, two 32:1 read muxes with the zero and bypass override, and the operand latch.
- Estimated size is about 150 lines.

## Test plan
- Reset: assert reset_0 between clock edges → rdata_a=rdata_b=0 and rvalid=0 at once. After release, reading any register returns 0.
- Write then read: write reg 5 = 0xDEADBEEF, next cycle raddr_a=5 with rd_en=1 → rdata_a=0xDEADBEEF and rvalid=1 one edge later.
- Zero register: write reg 0 = 0xFFFFFFFF, then raddr_a=raddr_b=0 → both 0.
- Bypass: same cycle we=1, waddr=7, wdata=0x12345678, raddr_b=7, rd_en=1 → rdata_b=0x12345678. Following read of reg 7 → same value.
- Stall and write: latch reg 3 (=0x11), hold rd_en=0 for 3 cycles while writing reg 3 = 0x22 → rdata_a stays 0x11. Raising rd_en → 0x22.
- Flush priority: flush=1 with rd_en=1 on a valid address → rdata_a=rdata_b=0 and rvalid=0. A concurrent write still lands in the target register.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants, operand-latch type and small helpers for the MIPS
// register file and its storage cells.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // Contents of the ID/EX operand latch; valid=0 marks a bubble.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              valid;
  } operand_t;

  localparam operand_t BUBBLE = '0;

  function automatic logic isBypass(input logic              wrEn,
                                    input logic [ADDR_W-1:0] wrAddr,
                                    input logic [ADDR_W-1:0] rdAddr);
    return wrEn && (wrAddr == rdAddr);
  endfunction

endpackage

// File: rtl/reg_file_cell.sv
// One general-purpose register: a DATA_W-bit enabled flop with asynchronous
// active-low clear.
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: one write port, two bypassed read ports and a
// registered operand latch with stall/flush feeding the ID/EX boundary.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clock,
  input  logic              reset_0,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid
);

  logic [NUM_REGS-1:1] wrSel;
  logic [DATA_W-1:0]   regQ [NUM_REGS];
  logic [DATA_W-1:0]   readA;
  logic [DATA_W-1:0]   readB;
  operand_t            latch_q;
  operand_t            latch_d;

  // One-hot write decoder; register 0 has no select so its writes vanish.
  always_comb begin
    wrSel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wrSel[i] = we && (waddr == ADDR_W'(i));
    end
  end

  assign regQ[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : gen_regs
    reg_cell #(
      .W(DATA_W)
    ) u_cell (
      .clk_i (clock),
      .rst_ni(reset_0),
      .en_i  (wrSel[i]),
      .d_i   (wdata),
      .q_o   (regQ[i])
    );
  end

  always_comb begin
    readA = regQ[raddr_a];
    if (raddr_a == ZERO_REG) begin
      readA = '0;
    end else if (isBypass(we, waddr, raddr_a)) begin
      readA = wdata;
    end
  end

  always_comb begin
    readB = regQ[raddr_b];
    if (raddr_b == ZERO_REG) begin
      readB = '0;
    end else if (isBypass(we, waddr, raddr_b)) begin
      readB = wdata;
    end
  end

  // Flush beats capture; with neither, the latch holds (stall), even if the
  // register it came from is rewritten meanwhile.
  always_comb begin
    latch_d = latch_q;
    if (flush) begin
      latch_d = BUBBLE;
    end else if (rd_en) begin
      latch_d.a     = readA;
      latch_d.b     = readB;
      latch_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      latch_q <= BUBBLE;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign rdata_a = latch_q.a;
  assign rdata_b = latch_q.b;
  assign rvalid  = latch_q.valid;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array model of the architectural state
// checked every cycle, plus directed vectors with literal expectations.
module tb_reg_file;

  logic        clock;
  logic        reset_0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        rd_en;
  logic        flush;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        rvalid;

  int checksDone;
  int checksPassed;
  bit compareOn;

  logic [31:0] mem [32];
  logic [31:0] expA;
  logic [31:0] expB;
  logic        expValid;

  reg_file dut (
    .clock  (clock),
    .reset_0(reset_0),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .rd_en  (rd_en),
    .flush  (flush),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b),
    .rvalid (rvalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (we && waddr == addr) return wdata;
    return mem[addr];
  endfunction

  always @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      expA = 32'd0;
      expB = 32'd0;
      expValid = 1'b0;
    end else begin
      if (flush) begin
        expA = 32'd0;
        expB = 32'd0;
        expValid = 1'b0;
      end else if (rd_en) begin
        expA = modelRead(raddr_a);
        expB = modelRead(raddr_b);
        expValid = 1'b1;
      end
      if (we && waddr != 5'd0) mem[waddr] = wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksDone++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (compareOn) begin
      checkOutput("model_rdata_a", rdata_a, expA);
      checkOutput("model_rdata_b", rdata_b, expB);
      checkOutput("model_rvalid", {31'd0, rvalid}, {31'd0, expValid});
    end
  end

  task automatic applyStimulus(input logic wEn, input logic [4:0] wA,
                               input logic [31:0] wD, input logic [4:0] rA,
                               input logic [4:0] rB, input logic rEn,
                               input logic fl);
    @(posedge clock);
    #1;
    we = wEn; waddr = wA; wdata = wD;
    raddr_a = rA; raddr_b = rB; rd_en = rEn; flush = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checksDone = 0;
    checksPassed = 0;
    compareOn = 1'b0;
    reset_0 = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; rd_en = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_0 = 1'b1;
    compareOn = 1'b1;

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd31, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("post_reset_a", rdata_a, 32'd0);
    checkOutput("post_reset_b", rdata_b, 32'd0);
    checkOutput("post_reset_valid", {31'd0, rvalid}, 32'd1);

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("write_read_a", rdata_a, 32'hDEADBEEF);
    checkOutput("write_read_valid", {31'd0, rvalid}, 32'd1);

    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("zero_reg_a", rdata_a, 32'd0);
    checkOutput("zero_reg_b", rdata_b, 32'd0);

    applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd7, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("bypass_b", rdata_b, 32'h12345678);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("stored_7_a", rdata_a, 32'h12345678);
    checkOutput("stored_7_b", rdata_b, 32'h12345678);

    applyStimulus(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd3, 32'h22, 5'd3, 5'd0, 1'b0, 1'b0);
    idle();
    idle();
    @(negedge clock);
    checkOutput("stall_hold_a", rdata_a, 32'h11);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("stall_release_a", rdata_a, 32'h22);

    applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 5'd5, 5'd7, 1'b1, 1'b1);
    idle();
    @(negedge clock);
    checkOutput("flush_a", rdata_a, 32'd0);
    checkOutput("flush_b", rdata_b, 32'd0);
    checkOutput("flush_valid", {31'd0, rvalid}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd5, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("flush_write_landed", rdata_a, 32'hA5A5A5A5);
    checkOutput("port_b_independent", rdata_b, 32'hDEADBEEF);

    applyStimulus(1'b1, 5'd31, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd1, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("reg31_a", rdata_a, 32'hCAFEF00D);
    checkOutput("reg1_b", rdata_b, 32'd0);

    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h01010101 * i ^ 32'h5A000000, 5'(i),
                    5'(32 - i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), (i % 3) != 0,
                    (i % 7) == 6);
    end
    idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("sweep_reg4", rdata_a, 32'h5E040404);

    applyStimulus(1'b1, 5'd12, 32'h77777777, 5'd5, 5'd4, 1'b1, 1'b0);
    #2;
    reset_0 = 1'b0;
    #1;
    checkOutput("async_reset_a", rdata_a, 32'd0);
    checkOutput("async_reset_b", rdata_b, 32'd0);
    checkOutput("async_reset_valid", {31'd0, rvalid}, 32'd0);
    @(posedge clock);
    #1;
    reset_0 = 1'b1;
    we = 1'b0; rd_en = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd12, 5'd5, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    checkOutput("lost_write_12", rdata_a, 32'd0);
    checkOutput("reset_cleared_5", rdata_b, 32'd0);

    idle();
    @(negedge clock);
    compareOn = 1'b0;
    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
